// File: rtl/uart_alu_interface_if.sv
// Bus between the UART receiver/transmitter, the ALU and the frame collector.
// The collector itself uses the slave side; the surrounding UART/ALU logic
// (or a test environment) uses the master side.
interface uart_alu_interface_if #(
    parameter int N   = 8,
    parameter int OPW = 6
);
    logic           rx_done_tick;
    logic [N-1:0]   rx_data;
    logic [N-1:0]   alu_result;
    logic           tx_done_tick;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [OPW-1:0] alu_op;
    logic           tx_start;
    logic [N-1:0]   tx_data;
    logic           frame_err;
    logic           overrun;

    modport slave (
        input  rx_done_tick, rx_data, alu_result, tx_done_tick,
        output alu_a, alu_b, alu_op, tx_start, tx_data, frame_err, overrun
    );

    modport master (
        output rx_done_tick, rx_data, alu_result, tx_done_tick,
        input  alu_a, alu_b, alu_op, tx_start, tx_data, frame_err, overrun
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Frame collector between UART Rx and Tx: gathers operand A, operand B and
// opcode bytes, presents them to an external combinational ALU, latches the
// result and launches it on the transmitter. Partial frames are dropped when
// the gap between bytes reaches TIMEOUT cycles (TIMEOUT = 0 disables this).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   WAIT_A  | idle, next byte is operand A, timer held at 0
//   WAIT_B  | A captured, waiting for operand B
//   WAIT_OP | B captured, waiting for opcode byte
//   EXEC    | one cycle for the ALU to settle, result latched
//   SEND    | tx_start high for this cycle only
//   WAIT_TX | waiting for tx_done_tick, tx_data held
module uart_alu_interface #(
    parameter int N       = 8,
    parameter int OPW     = 6,
    parameter int TIMEOUT = 50000
) (
    input logic               clk,
    input logic               reset,
    uart_alu_interface_if.slave bus
);

    // Timer only ever has to reach TIMEOUT-1, so it never wraps.
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TMAX = TW'(TLIM);

    typedef enum logic [5:0] {
        WAIT_A  = 6'b000001,
        WAIT_B  = 6'b000010,
        WAIT_OP = 6'b000100,
        EXEC    = 6'b001000,
        SEND    = 6'b010000,
        WAIT_TX = 6'b100000
    } state_t;

    state_t         state_q;
    logic [TW-1:0]  timer_q;
    logic [N-1:0]   alu_a_q;
    logic [N-1:0]   alu_b_q;
    logic [OPW-1:0] alu_op_q;
    logic [N-1:0]   tx_data_q;
    logic           tx_start_q;
    logic           frame_err_q;
    logic           overrun_q;

    logic timeout_hit;
    logic unused_rx_hi;

    // Expiry is only meaningful while a frame is partially collected.
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMAX);

    // Opcode uses only the low OPW bits of the received byte.
    assign unused_rx_hi = ^bus.rx_data[N-1:OPW];

    // Frame sequencing, timeout timer and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_A;
            timer_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                WAIT_A: begin
                    timer_q <= '0;
                    if (bus.rx_done_tick) begin
                        alu_a_q <= bus.rx_data;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.rx_done_tick) begin
                        alu_b_q <= bus.rx_data;
                        timer_q <= '0;
                        state_q <= WAIT_OP;
                    end else if (timeout_hit) begin
                        timer_q     <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_A;
                    end else if (TIMEOUT != 0) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_OP: begin
                    if (bus.rx_done_tick) begin
                        alu_op_q <= bus.rx_data[OPW-1:0];
                        timer_q  <= '0;
                        state_q  <= EXEC;
                    end else if (timeout_hit) begin
                        timer_q     <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_A;
                    end else if (TIMEOUT != 0) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                EXEC: begin
                    if (bus.rx_done_tick) overrun_q <= 1'b1;
                    tx_data_q  <= bus.alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (bus.rx_done_tick) overrun_q <= 1'b1;
                    state_q <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.rx_done_tick) overrun_q <= 1'b1;
                    if (bus.tx_done_tick) state_q <= WAIT_A;
                end
                default: begin
                    timer_q <= '0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: two instances (TIMEOUT=16 and TIMEOUT=0) see
// the same byte stream; a frame-level model predicts both every cycle, and
// directed literal checks pin the model at the interesting points.
module tb_uart_alu_interface;

    localparam int N   = 8;
    localparam int OPW = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_tick = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       txd_tick = 1'b0;
    bit         cmp_en = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_alu_interface_if #(.N(N), .OPW(OPW)) if16 ();
    uart_alu_interface_if #(.N(N), .OPW(OPW)) if0 ();

    uart_alu_interface #(.N(N), .OPW(OPW), .TIMEOUT(16)) dut16 (
        .clk(clk), .reset(reset), .bus(if16.slave));
    uart_alu_interface #(.N(N), .OPW(OPW), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign if16.rx_done_tick = rx_tick;
    assign if16.rx_data      = rx_byte;
    assign if16.tx_done_tick = txd_tick;
    assign if16.alu_result   = alu(if16.alu_a, if16.alu_b, if16.alu_op);
    assign if0.rx_done_tick  = rx_tick;
    assign if0.rx_data       = rx_byte;
    assign if0.tx_done_tick  = txd_tick;
    assign if0.alu_result    = alu(if0.alu_a, if0.alu_b, if0.alu_op);

    // ---------------- frame-level model ----------------
    // phase: 0 collecting bytes, 1 computing, 2 launched, 3 waiting for Tx
    int         to_cfg [2] = '{16, 0};
    int         m_cnt [2] = '{0, 0};
    int         m_ph  [2] = '{0, 0};
    int         m_gap [2] = '{0, 0};
    logic [7:0] m_a   [2] = '{8'h00, 8'h00};
    logic [7:0] m_b   [2] = '{8'h00, 8'h00};
    logic [5:0] m_op  [2] = '{6'h00, 6'h00};
    logic [7:0] m_txd [2] = '{8'h00, 8'h00};
    bit         m_ts  [2] = '{0, 0};
    bit         m_fe  [2] = '{0, 0};
    bit         m_ov  [2] = '{0, 0};

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_cnt[i] = 0; m_ph[i] = 0; m_gap[i] = 0;
                m_a[i] = 0; m_b[i] = 0; m_op[i] = 0; m_txd[i] = 0;
                m_ts[i] = 0; m_fe[i] = 0; m_ov[i] = 0;
            end else begin
                m_ts[i] = 0;
                m_fe[i] = 0;
                if (m_ph[i] != 0 && rx_tick) m_ov[i] = 1;
                case (m_ph[i])
                    0: begin
                        if (rx_tick) begin
                            if (m_cnt[i] == 0) m_a[i] = rx_byte;
                            else if (m_cnt[i] == 1) m_b[i] = rx_byte;
                            else m_op[i] = rx_byte[5:0];
                            m_gap[i] = 0;
                            if (m_cnt[i] == 2) begin
                                m_cnt[i] = 0;
                                m_ph[i] = 1;
                            end else begin
                                m_cnt[i]++;
                            end
                        end else if (m_cnt[i] > 0 && to_cfg[i] != 0) begin
                            m_gap[i]++;
                            if (m_gap[i] == to_cfg[i]) begin
                                m_cnt[i] = 0;
                                m_gap[i] = 0;
                                m_fe[i] = 1;
                            end
                        end
                    end
                    1: begin
                        m_txd[i] = alu(m_a[i], m_b[i], m_op[i]);
                        m_ts[i] = 1;
                        m_ph[i] = 2;
                    end
                    2: m_ph[i] = 3;
                    default: if (txd_tick) m_ph[i] = 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m16.alu_a", 32'(if16.alu_a), 32'(m_a[0]));
            chk("m16.alu_b", 32'(if16.alu_b), 32'(m_b[0]));
            chk("m16.alu_op", 32'(if16.alu_op), 32'(m_op[0]));
            chk("m16.tx_start", 32'(if16.tx_start), 32'(m_ts[0]));
            chk("m16.tx_data", 32'(if16.tx_data), 32'(m_txd[0]));
            chk("m16.frame_err", 32'(if16.frame_err), 32'(m_fe[0]));
            chk("m16.overrun", 32'(if16.overrun), 32'(m_ov[0]));
            chk("m0.alu_a", 32'(if0.alu_a), 32'(m_a[1]));
            chk("m0.alu_b", 32'(if0.alu_b), 32'(m_b[1]));
            chk("m0.alu_op", 32'(if0.alu_op), 32'(m_op[1]));
            chk("m0.tx_start", 32'(if0.tx_start), 32'(m_ts[1]));
            chk("m0.tx_data", 32'(if0.tx_data), 32'(m_txd[1]));
            chk("m0.frame_err", 32'(if0.frame_err), 32'(m_fe[1]));
            chk("m0.overrun", 32'(if0.overrun), 32'(m_ov[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_tick = 1'b1;
        step();
        rx_tick = 1'b0;
    endtask

    task automatic tx_done();
        txd_tick = 1'b1;
        step();
        txd_tick = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".alu_a"}, 32'(if16.alu_a), 32'h0);
        chk({tag, ".alu_b"}, 32'(if16.alu_b), 32'h0);
        chk({tag, ".alu_op"}, 32'(if16.alu_op), 32'h0);
        chk({tag, ".tx_start"}, 32'(if16.tx_start), 32'h0);
        chk({tag, ".tx_data"}, 32'(if16.tx_data), 32'h0);
        chk({tag, ".frame_err"}, 32'(if16.frame_err), 32'h0);
        chk({tag, ".overrun"}, 32'(if16.overrun), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk_all_zero("reset");
        #10 reset = 1'b1;
        cmp_en = 1'b1;
        step();

        // stray tx_done in WAIT_A must do nothing
        tx_done();
        chk("stray_txdone.tx_start", 32'(if16.tx_start), 32'h0);

        // T1: 5 + 3
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        chk("t1.alu_a", 32'(if16.alu_a), 32'h05);
        chk("t1.alu_b", 32'(if16.alu_b), 32'h03);
        chk("t1.alu_op", 32'(if16.alu_op), 32'h20);
        chk("t1.exec_no_start", 32'(if16.tx_start), 32'h0);
        step();
        chk("t1.tx_start", 32'(if16.tx_start), 32'h1);
        chk("t1.tx_data", 32'(if16.tx_data), 32'h08);
        step();
        chk("t1.tx_start_end", 32'(if16.tx_start), 32'h0);
        chk("t1.tx_data_hold", 32'(if16.tx_data), 32'h08);

        // T2: byte during WAIT_TX is dropped, then a second transfer
        send_byte(8'h0F);
        chk("t2.overrun", 32'(if16.overrun), 32'h1);
        chk("t2.alu_a_kept", 32'(if16.alu_a), 32'h05);
        step();
        step();
        chk("t2.no_start", 32'(if16.tx_start), 32'h0);
        tx_done();
        send_byte(8'h0F);
        send_byte(8'h01);
        send_byte(8'h22);
        chk("t2.alu_a", 32'(if16.alu_a), 32'h0F);
        step();
        chk("t2.tx_start", 32'(if16.tx_start), 32'h1);
        chk("t2.tx_data", 32'(if16.tx_data), 32'h0E);
        step();
        tx_done();

        // T3: lone byte times out after 16 cycles, then a fresh frame
        send_byte(8'hAA);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("t3.frame_err_c%0d", i), 32'(if16.frame_err), (i == 16) ? 32'h1 : 32'h0);
        end
        step();
        chk("t3.frame_err_pulse", 32'(if16.frame_err), 32'h0);
        chk("t3.no_frame_err_to0", 32'(if0.frame_err), 32'h0);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h25);
        chk("t3.alu_a", 32'(if16.alu_a), 32'h10);
        step();
        chk("t3.tx_data", 32'(if16.tx_data), 32'h30);
        chk("t3.to0_tx_data", 32'(if0.tx_data), 32'hBA);
        step();
        tx_done();

        // T4: byte landing on the expiry cycle is accepted
        send_byte(8'hAA);
        for (int i = 1; i <= 15; i++) step();
        send_byte(8'h03);
        chk("t4.frame_err", 32'(if16.frame_err), 32'h0);
        chk("t4.alu_b", 32'(if16.alu_b), 32'h03);
        send_byte(8'h20);
        step();
        chk("t4.tx_start", 32'(if16.tx_start), 32'h1);
        chk("t4.tx_data", 32'(if16.tx_data), 32'hAD);
        step();
        tx_done();

        // T5: reset in WAIT_OP, then reset in SEND
        send_byte(8'h01);
        send_byte(8'h02);
        #2 reset = 1'b0;
        #1 chk_all_zero("t5a");
        #3 reset = 1'b1;
        step();
        send_byte(8'h07);
        send_byte(8'h08);
        send_byte(8'h20);
        step();
        chk("t5.start_before_rst", 32'(if16.tx_start), 32'h1);
        #2 reset = 1'b0;
        #1 chk_all_zero("t5b");
        #3 reset = 1'b1;
        step();
        step();
        chk("t5.no_start_after", 32'(if16.tx_start), 32'h0);
        send_byte(8'h09);
        send_byte(8'h04);
        send_byte(8'h22);
        chk("t5.alu_a", 32'(if16.alu_a), 32'h09);
        step();
        chk("t5.tx_data", 32'(if16.tx_data), 32'h05);
        step();
        tx_done();

        // T6: long gaps, timeout disabled on dut0
        send_byte(8'h01);
        repeat (10000) step();
        send_byte(8'h02);
        repeat (10000) step();
        send_byte(8'h20);
        step();
        chk("t6.tx_start", 32'(if0.tx_start), 32'h1);
        chk("t6.tx_data", 32'(if0.tx_data), 32'h03);
        chk("t6.to16_alu_a", 32'(if16.alu_a), 32'h20);
        step();
        tx_done();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
